// File: rtl/mp_add_seq_if.sv
// rtl/mp_add_seq_if.sv - request/result bundle between the operand-issuing core and mp_add_seq
interface mp_add_seq_if #(
  parameter int N     = 64,
  parameter int LIMBS = 4
);
  localparam int W = N * LIMBS;

  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_carry_in;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_c;
  logic         o_carry_out;
  logic         o_busy;

  modport master (
    output i_valid, i_a, i_b, i_carry_in, i_sub, i_ready,
    input  o_ready, o_valid, o_c, o_carry_out, o_busy
  );

  modport slave (
    input  i_valid, i_a, i_b, i_carry_in, i_sub, i_ready,
    output o_ready, o_valid, o_c, o_carry_out, o_busy
  );
endinterface

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - multi-precision add sequencer, one N-bit limb per cycle, LSB limb first
// Optional subtraction (A-B via ~B + 1) is compiled in when MPADD_SUB_EN is defined.
module mp_add_seq #(
  parameter int N     = 64,
  parameter int LIMBS = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mp_add_seq_if.slave  bus
);
  localparam int W  = N * LIMBS;
  localparam int IW = $clog2(LIMBS);
  localparam logic [IW-1:0] LAST_IDX = IW'(LIMBS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  c_q;
  logic          carry_q;
  logic          cout_q;
  logic [IW-1:0] idx;
  logic [N-1:0]  a_limb;
  logic [N-1:0]  b_limb;
  logic [N:0]    limb_sum;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_valid) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.i_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign a_limb   = a_q[int'(idx) * N +: N];
  assign b_limb   = b_q[int'(idx) * N +: N];
  assign limb_sum = {1'b0, a_limb} + {1'b0, b_limb} + {{N{1'b0}}, carry_q};

  // b_q holds B already inverted for subtraction, so the RUN datapath is add-only.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      a_q <= bus.i_a;
      idx <= '0;
`ifdef MPADD_SUB_EN
      b_q     <= bus.i_sub ? ~bus.i_b : bus.i_b;
      carry_q <= bus.i_sub ? 1'b1 : bus.i_carry_in;
`else
      b_q     <= bus.i_b;
      carry_q <= bus.i_carry_in;
`endif
    end else if (state == S_RUN) begin
      c_q[int'(idx) * N +: N] <= limb_sum[N-1:0];
      carry_q                 <= limb_sum[N];
      if (idx == LAST_IDX) begin
        cout_q <= limb_sum[N];
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifndef MPADD_SUB_EN
  logic unused_sub;
  assign unused_sub = bus.i_sub;
`endif

  assign bus.o_ready     = (state == S_IDLE);
  assign bus.o_valid     = (state == S_DONE);
  assign bus.o_busy      = (state == S_RUN);
  assign bus.o_c         = c_q;
  assign bus.o_carry_out = cout_q;
endmodule
